// File: rtl/result_writer.sv
// Write-back stage: requantises 24-bit accumulator results to 8 bits, buffers them
// in a small FIFO and writes them to the output feature-map RAM at sequential addresses.
//
//   state  | meaning
//   S_IDLE | waiting for start; configuration not yet latched
//   S_RUN  | accepting results and writing them as the RAM port is granted
//   S_FIN  | all results written; done pulses for this one cycle
module result_writer #(
    parameter int ADDR_W     = 10,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] s_out_addr,
    input  logic [ADDR_W-1:0] out_count,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    input  logic [ACC_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    output logic              o_ena,
    output logic              o_we,
    input  logic              o_grant,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic signed [ACC_W:0] SAT_HI_U = 255;
    localparam logic signed [ACC_W:0] SAT_HI_S = 127;
    localparam logic signed [ACC_W:0] SAT_LO_S = -128;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [4:0]        r_shift;
    logic              r_relu;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_acc_cnt;
    logic              r_ovf;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [LVL_W-1:0]  r_level;

    logic              w_run;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [ADDR_W-1:0] w_wr_cnt_nxt;

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_shifted;
    logic [7:0]            w_qdata;

    assign w_run   = (r_state == S_RUN);
    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);

    // Acceptance is capped at out_count so the FIFO never holds surplus results.
    assign w_push       = w_run && in_valid && !w_full && (r_acc_cnt < r_count);
    assign w_pop        = w_run && !w_empty && o_grant;
    assign w_drop       = in_valid && !w_push;
    assign w_wr_cnt_nxt = r_wr_cnt + ADDR_W'(w_pop);

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        w_ext = {in_data[ACC_W-1], in_data};
        if (r_relu && in_data[ACC_W-1]) begin
            w_ext = '0;
        end
        w_rnd = '0;
        if (r_shift != 5'd0) begin
            w_rnd = (ACC_W+1)'(1) << (r_shift - 5'd1);
        end
        w_shifted = (w_ext + w_rnd) >>> r_shift;
        w_qdata   = w_shifted[7:0];
        if (r_relu) begin
            if (w_shifted > SAT_HI_U) begin
                w_qdata = 8'hFF;
            end
        end else begin
            if (w_shifted > SAT_HI_S) begin
                w_qdata = 8'h7F;
            end else if (w_shifted < SAT_LO_S) begin
                w_qdata = 8'h80;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (out_count == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                // Leaving on the final write edge puts done in the very next cycle.
                if (w_wr_cnt_nxt == r_count) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_count   <= '0;
            r_shift   <= '0;
            r_relu    <= 1'b0;
            r_wr_cnt  <= '0;
            r_acc_cnt <= '0;
            r_ovf     <= 1'b0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_level   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_base    <= s_out_addr;
                r_count   <= out_count;
                r_shift   <= shift;
                r_relu    <= relu_en;
                r_wr_cnt  <= '0;
                r_acc_cnt <= '0;
                r_ovf     <= 1'b0;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_level   <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_qdata;
                    r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                    r_acc_cnt       <= r_acc_cnt + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_wr_cnt <= w_wr_cnt_nxt;
                r_level  <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign in_ready = w_run && !w_full;
    assign o_ena    = w_pop;
    assign o_we     = w_pop;
    assign o_addr   = w_pop ? (r_base + r_wr_cnt) : '0;
    assign o_data   = w_pop ? r_mem[r_rd_ptr] : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);
    assign overflow = r_ovf;

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Write-back end of the convolution datapath: takes accumulated 24-bit results from the multiply-accumulate controller (one result per done pulse).
- Requantises each result to 8 bits and writes it to the output feature-map RAM at sequential addresses starting at a programmed base.
- A small FIFO decouples result arrival from RAM write-port availability.
- Signals done once the programmed number of results has been written.

Parameters:
- ADDR_W, 10, output RAM address width
- ACC_W, 24, accumulated result width
- FIFO_DEPTH, 4, result buffer entries (power of 2, at least 2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches configuration and begins a write run
- s_out_addr  in  ADDR_W  base address of the first result
- out_count  in  ADDR_W  number of results to write; 0 = no writes, done after one cycle
- shift  in  5  arithmetic right-shift amount, 0..23
- relu_en  in  1  1 = clamp negatives to 0 and saturate to unsigned 0..255; 0 = saturate to signed -128..127
- in_data  in  ACC_W  signed two's-complement accumulated result
- in_valid  in  1  result present this cycle (the producer's done pulse)
- in_ready  out  1  FIFO not full
- o_addr  out  ADDR_W  RAM write address
- o_data  out  8  RAM write data
- o_ena  out  1  RAM enable
- o_we  out  1  RAM write enable
- o_grant  in  1  RAM write port available this cycle
- busy  out  1  run in progress
- done  out  1  one-cycle pulse: run complete
- overflow  out  1  sticky; set when in_valid arrives while in_ready=0 or state is not RUN; cleared by rst or start

Behaviour:
- Reset values: in_ready=0, o_addr=0, o_data=0, o_ena=0, o_we=0, busy=0, done=0, overflow=0; FIFO emptied; state IDLE.
- States and transitions:
  - IDLE: on start, latch s_out_addr, out_count, shift and relu_en. Clear the write counter and overflow. Go to RUN, or to FIN if out_count=0.
  - RUN: accept inputs; write results; go to FIN when the write counter equals out_count.
  - FIN: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- busy=1 in RUN and FIN.
- in_ready=1 only in RUN and only when the FIFO is not full.
- Accepted results count toward accept_cnt. Once accept_cnt reaches out_count, later in_valid is dropped and sets overflow. The FIFO never holds more than out_count results.
- Requantise on FIFO push, in the same cycle as acceptance; the FIFO stores 8-bit values. Steps in order:
  1. If relu_en and in_data<0, use 0.
  2. Rounding: add 1<<(shift-1) when shift>0.
  3. Arithmetic right shift by shift. Compute in ACC_W+1 bits to avoid rounding overflow.
  4. Saturate: [0,255] if relu_en, else [-128,127].
- Write port:
  - A write fires in any RUN cycle with the FIFO non-empty and o_grant=1.
  - On a write cycle: o_ena=o_we=1, o_data=FIFO head, o_addr=base+write_cnt (mod 2^ADDR_W, wraps silently). Pop the FIFO and increment write_cnt.
  - Outputs are combinational from the head and counter; the RAM samples on the same edge. Latency from acceptance to earliest write is 1 cycle.
  - o_ena=o_we=0 when no write fires.
- Simultaneous push and pop with the FIFO full: allowed. in_ready reflects the pre-pop fullness, so a full FIFO refuses input even if it pops that cycle.
- done asserts in the cycle after the final write.
- rst mid-run: everything returns to reset values; buffered results are discarded and no further writes occur.

Test Plan:
- Basic run: start with s_out_addr=0x100, out_count=3, shift=0, relu_en=0; inputs 5, -3, 200, each followed by a gap; o_grant=1 → writes (0x100,0x05), (0x101,0xFD), (0x102,0x7F); done pulses one cycle after the last write.
- Requantise: shift=4, relu_en=1; inputs 0x000018, -100, 0x00FFFF → written 0x02 (24→round 1.5→2), 0x00, 0xFF (saturated).
- Backpressure: out_count=6; o_grant=0 for 10 cycles while 6 valids arrive back-to-back → in_ready falls after 4 are accepted, 5th valid sets overflow. Then o_grant=1 → 4 writes at consecutive addresses in order; done does not pulse, since only 4 of 6 results were written.
- Wrap and zero count: s_out_addr=0x3FE, out_count=3 → addresses 0x3FE, 0x3FF, 0x000. Separately, out_count=0 → done one cycle after start, no o_we.
- Reset mid-run: after 2 of 5 writes, assert rst for one cycle → all outputs 0, no writes afterwards. A new start runs cleanly from its base address.
- Ignored start: pulse start during RUN with a different s_out_addr → the addresses of the current run are unchanged.
